pl_intr_ctrl: RTL and testbench
===============================

# pl_intr_ctrl

Interrupt controller for the pipelined exception-capable CPU. Collects up to `NSRC` external interrupt request lines and latches rising edges as pending bits. Applies a software-written mask and selects the highest-priority unmasked source. Drives the CPU's single `intr` line through a request / acknowledge / end-of-interrupt handshake, and exposes the selected source ID so the `int_entry` handler can dispatch on it.

## Interface
Parameters:
- `NSRC`, 4, number of interrupt sources (2..16).
- `ID_W`, 2, width of source ID; must equal ceil(log2(`NSRC`)).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `irq`  in  NSRC  request lines; a rising edge is an event.
- `mask_we`  in  1  mask register write strobe.
- `mask_wdata`  in  NSRC  new mask value; 1 = source masked.
- `inta`  in  1  CPU acknowledge, 1-cycle pulse when the pipeline takes the interrupt.
- `eoi`  in  1  end of interrupt, 1-cycle pulse when the handler executes `eret`.
- `intr`  out  1  interrupt request to the CPU.
- `src_id`  out  ID_W  ID of the source being requested or serviced.
- `pending`  out  NSRC  latched pending bits.
- `mask`  out  NSRC  current mask register.
- `busy`  out  1  an interrupt is in service (acknowledged, no `eoi` yet).

## Operation
- **Edge detect**
  - `irq_q` is a register: `irq_q <= irq` every cycle, including during reset. A level held through reset therefore produces no event.
  - `edge = irq & ~irq_q`.
- **Pending bits**
  - Bit i sets when `edge[i]` is high.
  - Bit i clears when `inta` is accepted in REQ with `src_id == i`.
  - If set and clear hit the same bit in the same cycle, set wins.
- **Mask**
  - Written on `mask_we`, with the new value visible after the edge.
  - Masking does not clear pending bits.
- **Selection**
  - `cand = pending & ~mask`.
  - Priority goes to the lowest index (bit 0 highest).
- **FSM states:** IDLE, REQ, SERVICE.
  - IDLE:
    - If `cand != 0`, latch `src_id` = priority-encoded `cand` and go to REQ.
    - Otherwise stay in IDLE.
  - REQ:
    - `intr = 1`; `src_id` is frozen.
    - If `inta`, clear `pending[src_id]` and go to SERVICE.
    - Else, if `cand[src_id] == 0` (source masked meanwhile), go to IDLE with no acknowledge.
    - If both hold in the same cycle, `inta` wins.
  - SERVICE:
    - `intr = 0`, `busy = 1`.
    - On `eoi`, go to IDLE.
    - No nesting: new events only accumulate in `pending`.
- **Ignored inputs:**
  - `inta` outside REQ.
  - `eoi` outside SERVICE.
- **`src_id` hold:** keeps its last value in IDLE.
- **Reset values:**
  - state = IDLE.
  - `pending` = 0.
  - `mask` = all ones (all sources masked until software enables them, as with `c0_status`).
  - `src_id` = 0, `intr` = 0, `busy` = 0.

## Timing
- All outputs are registered. No combinational path from any input to `intr`, `busy` or `src_id`.
- **Request latency:**
  - `irq[i]` is first sampled high at edge k.
  - `pending[i]` is high after edge k.
  - REQ is entered and `intr` goes high after edge k+1 (2 cycles), provided the source is unmasked and the FSM is in IDLE.
- **Acknowledge:** `inta` sampled at edge m gives `intr` = 0, `busy` = 1 and `pending[src_id]` = 0 after edge m.
- **End of interrupt:**
  - `eoi` sampled at edge p gives `busy` = 0 after edge p.
  - If `cand != 0` at that point, `intr` rises again after edge p+1.
- **Mask write vs. evaluation:** a `mask_we` in the same cycle as an IDLE or REQ evaluation is not seen by it; the evaluation uses the old mask.
- **Reset mid-handshake:**
  - Returns to IDLE and clears `pending`.
  - Any later `inta` or `eoi` is ignored.

## Test plan
- **Reset state:**
  - Stimulus: hold `irq` = 4'b0011 through reset, release `rst`, run 5 cycles.
  - Required: `pending` = 0, `mask` = 4'b1111, `intr` = 0, `busy` = 0. No event is generated.
- **Single interrupt:**
  - Stimulus: write `mask` = 0, pulse `irq[2]`.
  - Required: `intr` high 2 cycles later with `src_id` = 2.
  - Stimulus: `inta`. Required: `intr` = 0, `busy` = 1, `pending` = 0.
  - Stimulus: `eoi`. Required: `busy` = 0.
- **Priority and queuing:**
  - Stimulus: `mask` = 0, `irq[3]` and `irq[1]` rise together.
  - Required: `src_id` = 1 first. After `inta` / `eoi`, `intr` rises again with `src_id` = 3.
- **Masked source:**
  - Stimulus: `mask` = 4'b0001, pulse `irq[0]`.
  - Required: `pending` = 4'b0001 and `intr` stays 0.
  - Stimulus: write `mask` = 0. Required: `intr` rises 1 cycle after the write is visible.
- **Withdrawal in REQ:**
  - Stimulus: in REQ with `src_id` = 0, write `mask` = 4'b0001 with no `inta`.
  - Required: `intr` drops, FSM returns to IDLE, `pending[0]` remains 1.
- **Simultaneous / illegal events:**
  - Stimulus: a new `irq[2]` edge on the same cycle `inta` acknowledges source 2. Required: `pending[2]` = 1 afterwards.
  - Stimulus: `eoi` in IDLE, `inta` in SERVICE. Required: no state change.

Source files
------------

// File: rtl/pl_intr_ctrl.sv
// pl_intr_ctrl: interrupt controller for the pipelined CPU.
// Latches rising edges of the irq lines as pending bits. Applies a software mask and picks the
// lowest-index unmasked source. Runs a request / acknowledge / end-of-interrupt handshake on intr.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   irq        in   [NSRC] request lines, rising edge = event
//   mask_we    in   mask register write strobe
//   mask_wdata in   [NSRC] new mask value, 1 = masked
//   inta       in   CPU acknowledge pulse, honoured only while requesting
//   eoi        in   end-of-interrupt pulse, honoured only while in service
//   intr       out  interrupt request to the CPU
//   src_id     out  [ID_W] source being requested or serviced
//   pending    out  [NSRC] latched pending bits
//   mask       out  [NSRC] current mask register
//   busy       out  interrupt in service
module pl_intr_ctrl #(
  parameter int unsigned NSRC = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wdata,
  input  logic            inta,
  input  logic            eoi,
  output logic            intr,
  output logic [ID_W-1:0] src_id,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] mask,
  output logic            busy
);

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e            state_q, state_d;
  logic [NSRC-1:0]   irq_q;
  logic [NSRC-1:0]   pending_q, pending_d;
  logic [NSRC-1:0]   mask_q, mask_d;
  logic [ID_W-1:0]   src_id_q, src_id_d;
  logic [NSRC-1:0]   irq_edge;
  logic [NSRC-1:0]   cand;
  logic [NSRC-1:0]   ack_clr;
  logic [ID_W-1:0]   sel;

  assign irq_edge = irq & ~irq_q;
  assign cand     = pending_q & ~mask_q;

  // Lowest index wins: scan downwards so the last hit is the smallest index.
  always_comb begin
    sel = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (cand[i]) sel = ID_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    src_id_d = src_id_q;
    ack_clr  = '0;
    unique case (state_q)
      StIdle: begin
        if (|cand) begin
          src_id_d = sel;
          state_d  = StReq;
        end
      end
      StReq: begin
        if (inta) begin
          ack_clr[src_id_q] = 1'b1;
          state_d           = StService;
        end else if (!cand[src_id_q]) begin
          // Source masked while requesting: withdraw without acknowledge.
          state_d = StIdle;
        end
      end
      StService: begin
        if (eoi) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A new edge on the acknowledged source keeps it pending.
    pending_d = (pending_q & ~ack_clr) | irq_edge;
    mask_d    = mask_we ? mask_wdata : mask_q;
  end

  always_ff @(posedge clk) begin
    // Sampled even in reset so a level held through reset is not an event.
    irq_q <= irq;
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= '0;
      mask_q    <= '1;
      src_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      src_id_q  <= src_id_d;
    end
  end

  // Outputs decode registered state only; no input reaches them combinationally.
  assign intr    = (state_q == StReq);
  assign busy    = (state_q == StService);
  assign src_id  = src_id_q;
  assign pending = pending_q;
  assign mask    = mask_q;

endmodule

// File: tb/tb_pl_intr_ctrl.sv
// Self-checking bench for pl_intr_ctrl: directed handshake scenarios followed by random traffic.
// Every driven cycle steps a reference model and queues the expected post-edge outputs; a
// monitor pops and compares them one cycle later.
module tb_pl_intr_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] irq = '0;
  logic       mask_we = 1'b0;
  logic [3:0] mask_wdata = '0;
  logic       inta = 1'b0;
  logic       eoi = 1'b0;
  logic       intr;
  logic [1:0] src_id;
  logic [3:0] pending;
  logic [3:0] mask;
  logic       busy;

  pl_intr_ctrl #(.NSRC(4), .ID_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .inta       (inta),
    .eoi        (eoi),
    .intr       (intr),
    .src_id     (src_id),
    .pending    (pending),
    .mask       (mask),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       intr;
    logic       busy;
    logic [1:0] src_id;
    logic [3:0] pending;
    logic [3:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the set of pending sources, the mask, which source (if any) is being
  // requested, whether one is in service, and the last source id handed out.
  logic [3:0] m_prev = '0;
  logic [3:0] m_pend = '0;
  logic [3:0] m_mask = '1;
  int         m_req = -1;
  bit         m_svc = 1'b0;
  int         m_id = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input bit r, input logic [3:0] i, input bit we, input logic [3:0] wd,
                            input bit a, input bit e);
    logic [3:0] rises;
    logic [3:0] cand;
    int         pick;
    rises  = i & ~m_prev;
    m_prev = i;
    if (r) begin
      m_pend = '0;
      m_mask = '1;
      m_req  = -1;
      m_svc  = 1'b0;
      m_id   = 0;
    end else begin
      cand = m_pend & ~m_mask;
      if (m_svc) begin
        if (e) m_svc = 1'b0;
      end else if (m_req >= 0) begin
        if (a) begin
          m_pend[m_req] = 1'b0;
          m_svc = 1'b1;
          m_req = -1;
        end else if (!cand[m_req]) begin
          m_req = -1;
        end
      end else begin
        pick = -1;
        for (int k = 0; k < 4; k++) if (cand[k] && pick < 0) pick = k;
        if (pick >= 0) begin
          m_req = pick;
          m_id  = pick;
        end
      end
      m_pend = m_pend | rises;
      if (we) m_mask = wd;
    end
  endtask

  // Drive one cycle from a negedge, queue its expectation, return at the following negedge.
  task automatic cyc(input bit r, input logic [3:0] i, input bit we, input logic [3:0] wd,
                     input bit a, input bit e);
    exp_t x;
    rst = r; irq = i; mask_we = we; mask_wdata = wd; inta = a; eoi = e;
    model_step(r, i, we, wd, a, e);
    x.intr    = (m_req >= 0);
    x.busy    = m_svc;
    x.src_id  = 2'(m_id);
    x.pending = m_pend;
    x.mask    = m_mask;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  task automatic idle(input logic [3:0] i);
    cyc(1'b0, i, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("intr", int'(intr), int'(x.intr));
        chk("busy", int'(busy), int'(x.busy));
        chk("src_id", int'(src_id), int'(x.src_id));
        chk("pending", int'(pending), int'(x.pending));
        chk("mask", int'(mask), int'(x.mask));
      end
    end
  end

  initial begin : stim
    logic [3:0] ri;
    // Reset with irq[1:0] held high through it: no event afterwards.
    cyc(1'b1, 4'b0011, 1'b0, 4'h0, 1'b0, 1'b0);
    cyc(1'b1, 4'b0011, 1'b0, 4'h0, 1'b0, 1'b0);
    repeat (5) idle(4'b0011);
    chk("reset_pending", int'(pending), 0);
    chk("reset_mask", int'(mask), 4'hf);
    chk("reset_intr", int'(intr), 0);
    chk("reset_busy", int'(busy), 0);
    idle(4'b0000);

    // Single interrupt on source 2.
    cyc(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);
    idle(4'b0100);
    idle(4'b0000);
    chk("single_intr", int'(intr), 1);
    chk("single_src", int'(src_id), 2);
    cyc(1'b0, 4'b0000, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("ack_busy", int'(busy), 1);
    chk("ack_pending", int'(pending), 0);
    cyc(1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("eoi_busy", int'(busy), 0);

    // Sources 3 and 1 together: 1 first, then 3.
    idle(4'b1010);
    idle(4'b0000);
    chk("prio_first", int'(src_id), 1);
    cyc(1'b0, 4'b0000, 1'b0, 4'h0, 1'b1, 1'b0);
    cyc(1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, 1'b1);
    idle(4'b0000);
    chk("prio_second_intr", int'(intr), 1);
    chk("prio_second", int'(src_id), 3);
    cyc(1'b0, 4'b0000, 1'b0, 4'h0, 1'b1, 1'b0);
    cyc(1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, 1'b1);

    // Masked source 0 stays pending, then is released.
    cyc(1'b0, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0);
    idle(4'b0001);
    idle(4'b0000);
    idle(4'b0000);
    chk("masked_pending", int'(pending), 1);
    chk("masked_intr", int'(intr), 0);
    cyc(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);
    idle(4'b0000);
    chk("unmask_intr", int'(intr), 1);

    // Withdrawal in REQ: mask source 0 without acknowledge.
    cyc(1'b0, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0);
    idle(4'b0000);
    chk("withdraw_intr", int'(intr), 0);
    chk("withdraw_pending", int'(pending), 1);

    // Drain source 0, then ack source 2 on the same cycle as a new irq[2] edge.
    cyc(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);
    idle(4'b0000);
    cyc(1'b0, 4'b0000, 1'b0, 4'h0, 1'b1, 1'b0);
    cyc(1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, 1'b1);
    idle(4'b0100);
    idle(4'b0000);
    cyc(1'b0, 4'b0100, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("ack_vs_edge_pending", int'(pending), 4'b0100);
    cyc(1'b0, 4'b0000, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("inta_in_service", int'(busy), 1);
    cyc(1'b0, 4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0);
    cyc(1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, 1'b1);
    cyc(1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("eoi_in_idle_intr", int'(intr), 0);
    chk("eoi_in_idle_busy", int'(busy), 0);

    // Reset mid-handshake, then stray inta/eoi.
    cyc(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);
    idle(4'b0000);
    cyc(1'b0, 4'b0000, 1'b0, 4'h0, 1'b1, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0, 4'h0, 1'b0, 1'b0);
    cyc(1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, 1'b1);
    cyc(1'b0, 4'b0000, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_pending", int'(pending), 0);

    // Random traffic.
    ri = 4'b0000;
    for (int n = 0; n < 600; n++) begin
      bit         r, we, a, e;
      logic [3:0] wd;
      r  = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < 4; k++) if ($urandom_range(0, 3) == 0) ri[k] = ~ri[k];
      we = ($urandom_range(0, 11) == 0);
      wd = ($urandom_range(0, 2) == 0) ? 4'(($urandom() & 32'hf)) : 4'b0000;
      a  = (m_req >= 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) == 0);
      e  = m_svc ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      cyc(r, ri, we, wd, a, e);
    end

    idle(4'b0000);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
